// File: rtl/fetch_pc_gen.sv
// Fetch-PC generator: presents FW consecutive slot PCs from an aligned block base with a start-slot mask.
// Redirects show one cycle after request; a stall (VALID && !READY) holds every output stable.
module fetch_pc_gen #(
   parameter int              FW        = 2,
   parameter int              XLEN      = 32,
   parameter logic [XLEN-1:0] RESET_VEC = '0
) (
   input  logic               FPC_CLK,
   input  logic               FPC_RST_N,
   input  logic               FPC_READY,
   input  logic               FPC_TRAP,
   input  logic [XLEN-1:0]    FPC_TRAP_VEC,
   input  logic               FPC_BR,
   input  logic [XLEN-1:0]    FPC_BR_TGT,
   input  logic               FPC_HALT,
   output logic               FPC_VALID,
   output logic [FW*XLEN-1:0] FPC_PC,
   output logic [FW-1:0]      FPC_SLOT_VLD,
   output logic               FPC_MISALIGN
);

   localparam int              BW    = $clog2(FW * 4);
   localparam int              SSW   = (FW > 1) ? $clog2(FW) : 1;
   localparam logic [XLEN-1:0] BLK   = XLEN'(FW * 4);
   localparam logic [XLEN-1:0] AMASK = ~(BLK - XLEN'(1));

   localparam logic [1:0] ST_BOOT   = 2'd0;
   localparam logic [1:0] ST_RUN    = 2'd1;
   localparam logic [1:0] ST_HALTED = 2'd2;

   if (FW < 1 || FW > 8 || (FW & (FW - 1)) != 0) begin : g_bad_fw
      $error("fetch_pc_gen: FW must be a power of two in 1..8");
   end
   if ((RESET_VEC & ~AMASK) != '0) begin : g_bad_vec
      $error("fetch_pc_gen: RESET_VEC must be aligned to FW*4 bytes");
   end

   logic [XLEN-1:0] base_q, base_d;
   logic [SSW-1:0]  ss_q, ss_d;
   logic [1:0]      state_q, state_d;
   logic            mis_q;
   logic            redir;
   logic [XLEN-1:0] tgt, tgt_al;

   always_comb begin
      redir   = FPC_TRAP | FPC_BR;
      tgt     = FPC_TRAP ? FPC_TRAP_VEC : FPC_BR_TGT;
      tgt_al  = {tgt[XLEN-1:2], 2'b00};
      base_d  = base_q;
      ss_d    = ss_q;
      if (redir) begin
         base_d = tgt_al & AMASK;
         ss_d   = SSW'(tgt_al[BW-1:0] >> 2);
      end else if (state_q == ST_RUN && FPC_READY) begin
         base_d = base_q + BLK;
         ss_d   = '0;
      end
      // BOOT, RUN and HALTED all leave on the halt level alone; redirects never change state
      state_d = FPC_HALT ? ST_HALTED : ST_RUN;
   end

   always_ff @(posedge FPC_CLK or negedge FPC_RST_N) begin
      if (!FPC_RST_N) begin
         base_q  <= RESET_VEC;
         ss_q    <= '0;
         state_q <= ST_BOOT;
         mis_q   <= 1'b0;
      end else begin
         base_q  <= base_d;
         ss_q    <= ss_d;
         state_q <= state_d;
         mis_q   <= redir && (tgt[1:0] != 2'b00);
      end
   end

   assign FPC_VALID    = (state_q == ST_RUN);
   assign FPC_MISALIGN = mis_q;

   always_comb begin
      FPC_PC       = '0;
      FPC_SLOT_VLD = '0;
      for (int i = 0; i < FW; i++) begin
         FPC_PC[i*XLEN +: XLEN] = base_q + XLEN'(4 * i);
         FPC_SLOT_VLD[i]        = FPC_VALID && (SSW'(i) >= ss_q);
      end
   end

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Bench for fetch_pc_gen: FW=2 and FW=4 instances share stimulus; table rows, corner sequences, random vs model.
module tb_fetch_pc_gen;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, ready, trap, br, halt;
   logic [31:0] trap_vec, br_tgt;
   logic        v2, v4, mis2, mis4;
   logic [63:0]  pc2;
   logic [127:0] pc4;
   logic [1:0]  sv2;
   logic [3:0]  sv4;

   int n_chk  = 0;
   int n_fail = 0;

   fetch_pc_gen #(.FW(2), .XLEN(32), .RESET_VEC(32'h0)) u2 (
      .FPC_CLK(clk), .FPC_RST_N(rst_n), .FPC_READY(ready), .FPC_TRAP(trap),
      .FPC_TRAP_VEC(trap_vec), .FPC_BR(br), .FPC_BR_TGT(br_tgt), .FPC_HALT(halt),
      .FPC_VALID(v2), .FPC_PC(pc2), .FPC_SLOT_VLD(sv2), .FPC_MISALIGN(mis2));

   fetch_pc_gen #(.FW(4), .XLEN(32), .RESET_VEC(32'h100)) u4 (
      .FPC_CLK(clk), .FPC_RST_N(rst_n), .FPC_READY(ready), .FPC_TRAP(trap),
      .FPC_TRAP_VEC(trap_vec), .FPC_BR(br), .FPC_BR_TGT(br_tgt), .FPC_HALT(halt),
      .FPC_VALID(v4), .FPC_PC(pc4), .FPC_SLOT_VLD(sv4), .FPC_MISALIGN(mis4));

   // Reference model: the byte address of the first wanted instruction, plus a "fetching" flag.
   logic [31:0] m_pc2, m_pc4;
   bit          m_run, m_mis;

   function automatic logic [63:0] pcs2(input logic [31:0] b);
      return {b + 32'd4, b};
   endfunction

   function automatic logic [127:0] pcs4(input logic [31:0] b);
      return {b + 32'd12, b + 32'd8, b + 32'd4, b};
   endfunction

   function automatic logic [3:0] mask(input int fw, input logic [31:0] pc, input bit v);
      logic [3:0] m = '0;
      int off = int'(pc % (fw * 4));
      for (int i = 0; i < fw; i++) m[i] = v && (i * 4 >= off);
      return m;
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_pc2 = 32'h0;
      m_pc4 = 32'h100;
      m_run = 1'b0;
      m_mis = 1'b0;
   endtask

   task automatic model_edge();
      logic [31:0] t;
      if (!rst_n) return;
      t     = trap ? trap_vec : br_tgt;
      m_mis = (trap || br) && (t % 4 != 0);
      if (trap || br) begin
         m_pc2 = t - (t % 4);
         m_pc4 = t - (t % 4);
      end else if (m_run && ready) begin
         m_pc2 = m_pc2 - (m_pc2 % 8) + 8;
         m_pc4 = m_pc4 - (m_pc4 % 16) + 16;
      end
      m_run = !halt;
   endtask

   task automatic model_check(input string tag);
      chk({tag, ".valid2"}, v2, m_run);
      chk({tag, ".valid4"}, v4, m_run);
      chk({tag, ".mis2"}, mis2, m_mis);
      chk({tag, ".mis4"}, mis4, m_mis);
      chk({tag, ".pc2"}, pc2, pcs2(m_pc2 - (m_pc2 % 8)));
      chk({tag, ".pc4"}, pc4, pcs4(m_pc4 - (m_pc4 % 16)));
      chk({tag, ".slot2"}, sv2, mask(2, m_pc2, m_run));
      chk({tag, ".slot4"}, sv4, mask(4, m_pc4, m_run));
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic drive(input bit t, input logic [31:0] tv, input bit b, input logic [31:0] bt,
                        input bit h, input bit r);
      trap = t; trap_vec = tv; br = b; br_tgt = bt; halt = h; ready = r;
   endtask

   typedef struct {
      bit          trap;
      logic [31:0] tv;
      bit          br;
      logic [31:0] bt;
      bit          halt;
      bit          rdy;
      bit          v;
      bit          mis;
      logic [31:0] b2;
      logic [1:0]  m2;
      logic [31:0] b4;
      logic [3:0]  m4;
   } vec_t;

   function automatic vec_t mk(input bit t, input logic [31:0] tv, input bit b, input logic [31:0] bt,
                               input bit h, input bit r, input bit v, input bit mi,
                               input logic [31:0] b2, input logic [1:0] m2,
                               input logic [31:0] b4, input logic [3:0] m4);
      vec_t x;
      x.trap = t; x.tv = tv; x.br = b; x.bt = bt; x.halt = h; x.rdy = r;
      x.v = v; x.mis = mi; x.b2 = b2; x.m2 = m2; x.b4 = b4; x.m4 = m4;
      return x;
   endfunction

   vec_t tbl[21];

   initial begin
      //            trap vec          br tgt           h  r   v  mis  base2         m2     base4         m4
      tbl[0]  = mk(0, 0,        0, 0,            0, 1,  1, 0, 32'h0,        2'b11, 32'h100,      4'b1111);
      tbl[1]  = mk(0, 0,        0, 0,            0, 1,  1, 0, 32'h8,        2'b11, 32'h110,      4'b1111);
      tbl[2]  = mk(0, 0,        0, 0,            0, 1,  1, 0, 32'h10,       2'b11, 32'h120,      4'b1111);
      tbl[3]  = mk(0, 0,        1, 32'h20,       0, 1,  1, 0, 32'h20,       2'b11, 32'h20,       4'b1111);
      tbl[4]  = mk(0, 0,        0, 0,            0, 0,  1, 0, 32'h20,       2'b11, 32'h20,       4'b1111);
      tbl[5]  = mk(0, 0,        0, 0,            0, 0,  1, 0, 32'h20,       2'b11, 32'h20,       4'b1111);
      tbl[6]  = mk(0, 0,        0, 0,            0, 0,  1, 0, 32'h20,       2'b11, 32'h20,       4'b1111);
      tbl[7]  = mk(0, 0,        0, 0,            0, 1,  1, 0, 32'h28,       2'b11, 32'h30,       4'b1111);
      tbl[8]  = mk(0, 0,        1, 32'h108,      0, 0,  1, 0, 32'h108,      2'b11, 32'h100,      4'b1100);
      tbl[9]  = mk(0, 0,        0, 0,            0, 1,  1, 0, 32'h110,      2'b11, 32'h110,      4'b1111);
      tbl[10] = mk(1, 32'h80,   1, 32'h200,      0, 1,  1, 0, 32'h80,       2'b11, 32'h80,       4'b1111);
      tbl[11] = mk(0, 0,        1, 32'h206,      0, 1,  1, 1, 32'h200,      2'b10, 32'h200,      4'b1110);
      tbl[12] = mk(0, 0,        0, 0,            0, 0,  1, 0, 32'h200,      2'b10, 32'h200,      4'b1110);
      tbl[13] = mk(0, 0,        1, 32'hFFFFFFF8, 0, 1,  1, 0, 32'hFFFFFFF8, 2'b11, 32'hFFFFFFF0, 4'b1100);
      tbl[14] = mk(0, 0,        0, 0,            0, 1,  1, 0, 32'h0,        2'b11, 32'h0,        4'b1111);
      tbl[15] = mk(0, 0,        0, 0,            1, 1,  0, 0, 32'h8,        2'b00, 32'h10,       4'b0000);
      tbl[16] = mk(0, 0,        1, 32'h40,       1, 1,  0, 0, 32'h40,       2'b00, 32'h40,       4'b0000);
      tbl[17] = mk(0, 0,        0, 0,            1, 1,  0, 0, 32'h40,       2'b00, 32'h40,       4'b0000);
      tbl[18] = mk(0, 0,        0, 0,            0, 0,  1, 0, 32'h40,       2'b11, 32'h40,       4'b1111);
      tbl[19] = mk(1, 32'h1F,   0, 0,            0, 1,  1, 1, 32'h18,       2'b10, 32'h10,       4'b1000);
      tbl[20] = mk(0, 0,        0, 0,            0, 1,  1, 0, 32'h20,       2'b11, 32'h20,       4'b1111);

      rst_n = 1'b0;
      drive(0, 0, 0, 0, 0, 0);
      model_reset();
      #12;
      chk("rst.valid2", v2, 1'b0);
      chk("rst.valid4", v4, 1'b0);
      chk("rst.pc2", pc2, pcs2(32'h0));
      chk("rst.pc4", pc4, pcs4(32'h100));
      chk("rst.slots", {sv4, sv2}, 6'b0);
      chk("rst.mis", {mis4, mis2}, 2'b0);

      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("boot.valid", {v4, v2}, 2'b00);

      for (int k = 0; k < 21; k++) begin
         drive(tbl[k].trap, tbl[k].tv, tbl[k].br, tbl[k].bt, tbl[k].halt, tbl[k].rdy);
         step();
         chk($sformatf("row%0d.valid", k), {v4, v2}, {tbl[k].v, tbl[k].v});
         chk($sformatf("row%0d.mis", k), {mis4, mis2}, {tbl[k].mis, tbl[k].mis});
         chk($sformatf("row%0d.pc2", k), pc2, pcs2(tbl[k].b2));
         chk($sformatf("row%0d.pc4", k), pc4, pcs4(tbl[k].b4));
         chk($sformatf("row%0d.slot2", k), sv2, tbl[k].m2);
         chk($sformatf("row%0d.slot4", k), sv4, tbl[k].m4);
      end

      // Async reset in the middle of a stall, with a misalign pulse live.
      drive(0, 0, 1, 32'h33, 0, 0);
      step();
      chk("pre_rst.mis", {mis4, mis2}, 2'b11);
      drive(0, 0, 0, 0, 0, 0);
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("arst.valid", {v4, v2}, 2'b00);
      chk("arst.pc2", pc2, pcs2(32'h0));
      chk("arst.pc4", pc4, pcs4(32'h100));
      chk("arst.slots", {sv4, sv2}, 6'b0);
      chk("arst.mis", {mis4, mis2}, 2'b00);
      ready = 1'b1;
      step();
      chk("arst_hold.valid", {v4, v2}, 2'b00);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("arst_boot.valid", {v4, v2}, 2'b00);
      step();
      chk("arst_run.valid", {v4, v2}, 2'b11);
      chk("arst_run.pc2", pc2, pcs2(32'h0));
      chk("arst_run.pc4", pc4, pcs4(32'h100));
      step();
      chk("arst_adv.pc2", pc2, pcs2(32'h8));
      chk("arst_adv.pc4", pc4, pcs4(32'h110));

      for (int c = 0; c < 1500; c++) begin
         drive($urandom % 16 == 0, $urandom, $urandom % 8 == 0, $urandom,
               $urandom % 8 == 0, $urandom % 4 != 0);
         step();
         model_check($sformatf("rnd%0d", c));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/fetch_pc_gen.md
Name: fetch_pc_gen

Overview:
- Parametrised fetch-PC generator for the multi-issue OTTER front end; successor to the two-slot PC register.
- Holds an aligned fetch-block base and presents FW consecutive slot PCs with a per-slot valid mask.
- Advances under a valid/ready handshake with instruction memory.
- Accepts trap and branch redirects, including mid-block targets, plus a halt/resume control with a boot state.

Parameters:
- FW, 2, fetch width in instructions; power of two, 1..8.
- XLEN, 32, PC width in bits.
- RESET_VEC, 32'h0, reset PC; must be aligned to FW*4 (elaboration-time assertion).

Ports:
- FPC_CLK  in  1  clock; all state changes on rising edge.
- FPC_RST_N  in  1  reset, asynchronous assert, active-low; one clock, async active-low reset.
- FPC_READY  in  1  consumer accepts the current fetch block this cycle.
- FPC_TRAP  in  1  exception/interrupt flush request.
- FPC_TRAP_VEC  in  XLEN  trap target.
- FPC_BR  in  1  branch/jump redirect request (mispredict resolve).
- FPC_BR_TGT  in  XLEN  branch target.
- FPC_HALT  in  1  level-sensitive halt request.
- FPC_VALID  out  1  current fetch block is valid.
- FPC_PC  out  FW*XLEN  slot PCs; slot i occupies bits [i*XLEN +: XLEN].
- FPC_SLOT_VLD  out  FW  per-slot valid; bit i = slot i holds a wanted instruction.
- FPC_MISALIGN  out  1  one-cycle pulse: accepted redirect target had bits[1:0] != 0.

Behaviour:
- State: base register BASE (aligned to B = FW*4 bytes), start-slot register SS (log2 FW bits), FSM {BOOT, RUN, HALTED}.
- Outputs: FPC_PC slot i = BASE + 4*i, mod 2^XLEN. FPC_SLOT_VLD[i] = (i >= SS) && FPC_VALID. FPC_VALID = (state == RUN).
- Reset (async, FPC_RST_N=0):
  - BASE = RESET_VEC, SS = 0, state = BOOT.
  - FPC_VALID = 0, FPC_SLOT_VLD = 0, FPC_MISALIGN = 0.
  - Slot PCs = RESET_VEC + 4i; FW=2 gives 0/4.
  - Reset asserted mid-operation aborts everything immediately.
- BOOT: lasts exactly one cycle after reset release, then goes to RUN (HALTED if FPC_HALT=1). Redirects in BOOT are honoured.
- Next-state priority, evaluated each edge (highest first):
  1. FPC_TRAP: T = FPC_TRAP_VEC with bits[1:0] forced to 0; BASE = T & ~(B-1); SS = T[log2(B)-1:2].
  2. FPC_BR: same update using FPC_BR_TGT. Ignored if FPC_TRAP is also high.
  3. RUN && FPC_VALID && FPC_READY: BASE = BASE + B (wraps mod 2^XLEN); SS = 0.
  4. Otherwise hold BASE and SS. A stall (VALID && !READY) keeps all outputs stable.
- Redirect latency: request in cycle T → new PCs and mask visible in cycle T+1.
  - Redirect overrides a stall; the stalled block is discarded, not handed off.
  - Redirect while HALTED updates BASE/SS and the block stays HALTED.
- FPC_MISALIGN = registered (selected redirect target bits[1:0] != 0); high for exactly the cycle after acceptance, else 0.
- Halt:
  - RUN→HALTED on any edge with FPC_HALT=1; FPC_VALID drops next cycle.
  - A block handshaking (VALID && READY) on that same edge still advances BASE.
  - HALTED→RUN on the edge where FPC_HALT=0.
- FW=1: SS is constant 0; B = 4.

Test Plan:
- FW=2, reset release, READY=1 → cycle after BOOT: VALID=1, PCs 0/4, SLOT_VLD=2'b11; next cycles 8/C, 10/14.
- FW=4, READY=0 for 3 cycles at BASE=0x20 → PCs 0x20/24/28/2C held, VALID=1; READY=1 → 0x30..0x3C.
- FW=4, BR=1, TGT=0x108 → next cycle PCs 0x100..0x10C, SLOT_VLD=4'b1100; following block 0x110, mask 4'b1111.
- TRAP=1 (VEC=0x80) and BR=1 (TGT=0x200) same cycle → PCs 0x80/0x84, mask 2'b11; BR ignored. BR TGT=0x206 → base 0x200, SS=1, MISALIGN pulse of 1 cycle.
- BASE=0xFFFFFFF8, FW=2, handshake → PCs 0x0/0x4 (wrap). HALT=1 → VALID=0 next cycle; BR to 0x40 while halted → on HALT=0, PCs 0x40/0x44 valid.
- Assert FPC_RST_N=0 asynchronously mid-stall → VALID=0 immediately, PCs RESET_VEC/+4; BOOT lasts 1 cycle after release.
